// File: rtl/i2cs_rx.sv
// i2cs_rx: write-only I2C target that captures a two-byte word {byte1, byte2} and ACKs its own address.
// Define I2CS_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronised SCL/SDA.
module i2cs_rx #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, ADDR, AACK, DATA, DACK, WAITP} state_t;

  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_s, sda_s;
  logic        scl_f, sda_f;
  logic        scl_p_q, sda_p_q;
  logic        start_det, stop_det, scl_rise, scl_fall;

  state_t      state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q, byte1_q;
  logic        byte_idx_q;
  logic        sda_oe_q;
  logic [15:0] dout_q;
  logic        dout_valid_q, busy_q, frame_err_q;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_sclk};
      sda_sync_q <= {sda_sync_q[0], i2c_sdat};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

`ifdef I2CS_GLITCH_FILTER_EN
  logic [2:0] scl_flt_q, sda_flt_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_flt_q <= 3'b111;
      sda_flt_q <= 3'b111;
    end else begin
      scl_flt_q <= {scl_flt_q[1:0], scl_s};
      sda_flt_q <= {sda_flt_q[1:0], sda_s};
    end
  end

  assign scl_f = maj3(scl_flt_q);
  assign sda_f = maj3(sda_flt_q);
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;
  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;

  // Protocol FSM: STOP and START take priority over bit-level activity
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= 4'd0;
      shift_q      <= 8'h00;
      byte1_q      <= 8'h00;
      byte_idx_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (stop_det) begin
        if (state_q inside {ADDR, AACK, DATA, DACK}) frame_err_q <= 1'b1;
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        sda_oe_q   <= 1'b0;
        bitcnt_q   <= 4'd0;
        shift_q    <= 8'h00;
        byte1_q    <= 8'h00;
        byte_idx_q <= 1'b0;
      end else if (start_det) begin
        state_q    <= ADDR;
        busy_q     <= 1'b1;
        sda_oe_q   <= 1'b0;
        bitcnt_q   <= 4'd0;
        shift_q    <= 8'h00;
        byte1_q    <= 8'h00;
        byte_idx_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, DATA: begin
            if (scl_rise && bitcnt_q < 4'd8) begin
              shift_q  <= {shift_q[6:0], sda_f};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              if (state_q == DATA) begin
                state_q  <= DACK;
                sda_oe_q <= 1'b1;
              end else if (shift_q == {DEV_ADDR, 1'b0}) begin
                state_q  <= AACK;
                sda_oe_q <= 1'b1;
              end else begin
                state_q <= WAITP;
              end
            end
          end
          AACK, DACK: begin
            // Falling edge after the 9th clock ends the ACK slot
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 4'd0;
              if (state_q == AACK) begin
                state_q <= DATA;
              end else if (!byte_idx_q) begin
                byte1_q    <= shift_q;
                byte_idx_q <= 1'b1;
                state_q    <= DATA;
              end else begin
                dout_q       <= {byte1_q, shift_q};
                dout_valid_q <= 1'b1;
                state_q      <= WAITP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sdat   = sda_oe_q ? 1'b0 : 1'bz;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2cs_rx.sv
// Bench for i2cs_rx: bit-banged I2C initiator, directed scenarios plus random write transactions.
module tb_i2cs_rx;
  localparam int Q = 6;
  localparam logic [7:0] WADDR = 8'h34;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_sda_low;
  wire         sda_bus;
  logic [15:0] dout;
  logic        dout_valid, busy, frame_err;

  int n_cmp = 0;
  int n_mis = 0;
  int n_valid = 0, n_ferr = 0, n_busy_rise = 0, n_drv = 0;
  logic busy_prev = 1'b0;
  logic [15:0] model_dout;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2cs_rx #(.DEV_ADDR(7'h1A)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda_bus),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (busy === 1'b1 && busy_prev !== 1'b1) n_busy_rise <= n_busy_rise + 1;
    if (!m_sda_low && sda_bus === 1'b0) n_drv <= n_drv + 1;
    busy_prev <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; scl = 1'b1; wclk(2*Q);
    m_sda_low = 1'b1; wclk(2*Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0; wclk(Q);
    scl = 1'b1; wclk(2*Q);
    m_sda_low = 1'b1; wclk(2*Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wclk(Q);
    scl = 1'b1; wclk(2*Q);
    m_sda_low = 1'b0; wclk(2*Q);
  endtask

  task automatic i2c_bit(input logic b);
    m_sda_low = ~b; wclk(Q);
    scl = 1'b1; wclk(2*Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    m_sda_low = 1'b0; wclk(Q);
    scl = 1'b1; wclk(Q);
    ack = (sda_bus === 1'b0);
    wclk(Q);
    scl = 1'b0; wclk(Q);
  endtask

  // One START..STOP write; expectations come from word-level rules, not the RTL
  task automatic txn(input string tag, input bq_t b);
    logic ack, addressed, exp_ack;
    int v0, f0, d0;
    v0 = n_valid; f0 = n_ferr; d0 = n_drv;
    addressed = (b.size() > 0) && (b[0] == WADDR);
    i2c_start();
    chk({tag, "/busy_start"}, busy, 1'b1);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], ack);
      exp_ack = addressed && (i <= 2);
      chk($sformatf("%s/ack%0d", tag, i), ack, exp_ack);
    end
    i2c_stop();
    if (addressed && b.size() >= 3) model_dout = {b[1], b[2]};
    chk({tag, "/dout"}, dout, model_dout);
    chk({tag, "/valid_cnt"}, n_valid - v0, (addressed && b.size() >= 3) ? 1 : 0);
    chk({tag, "/ferr_cnt"}, n_ferr - f0, (addressed && b.size() < 3) ? 1 : 0);
    chk({tag, "/busy_stop"}, busy, 1'b0);
    if (!addressed) chk({tag, "/no_drive"}, n_drv - d0, 0);
  endtask

  initial begin
    bq_t q;
    logic ack;
    int v0, f0, b0;
    model_dout = 16'h0000;
    reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
    wclk(4);
    reset = 1'b0;
    wclk(2);
    chk("rst/dout", dout, 16'h0000);
    chk("rst/valid", dout_valid, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/ferr", frame_err, 1'b0);
    chk("rst/sda", sda_bus, 1'b1);

    q = '{8'h34, 8'h1E, 8'h00};
    txn("write_word", q);
    q = '{8'h36, 8'hAA, 8'h55};
    txn("wrong_addr", q);
    q = '{8'h35, 8'h12, 8'h34};
    txn("read_addr", q);
    q = '{8'h34, 8'h0E};
    txn("short_word", q);
    q = '{8'h34, 8'hC3, 8'h5A, 8'h77};
    txn("third_byte", q);

    // Repeated START discards the first partial word
    v0 = n_valid; f0 = n_ferr;
    i2c_start();
    send_byte(8'h34, ack); chk("rs/ack_a1", ack, 1'b1);
    send_byte(8'h02, ack); chk("rs/ack_d1", ack, 1'b1);
    i2c_rstart();
    chk("rs/busy", busy, 1'b1);
    send_byte(8'h34, ack); chk("rs/ack_a2", ack, 1'b1);
    send_byte(8'h04, ack); chk("rs/ack_d2", ack, 1'b1);
    send_byte(8'h79, ack); chk("rs/ack_d3", ack, 1'b1);
    i2c_stop();
    model_dout = 16'h0479;
    chk("rs/dout", dout, model_dout);
    chk("rs/valid_cnt", n_valid - v0, 1);
    chk("rs/ferr_cnt", n_ferr - f0, 0);

    // Reset in the middle of a data byte
    v0 = n_valid; f0 = n_ferr;
    i2c_start();
    send_byte(8'h34, ack); chk("mrst/ack", ack, 1'b1);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
    reset = 1'b1; wclk(2);
    m_sda_low = 1'b0; scl = 1'b1; wclk(2);
    reset = 1'b0; wclk(8);
    model_dout = 16'h0000;
    chk("mrst/busy", busy, 1'b0);
    chk("mrst/dout", dout, model_dout);
    chk("mrst/sda", sda_bus, 1'b1);
    chk("mrst/valid_cnt", n_valid - v0, 0);
    chk("mrst/ferr_cnt", n_ferr - f0, 0);
    q = '{8'h34, 8'hBE, 8'hEF};
    txn("after_rst", q);

    // Single-clock SDA glitch with SCL high
    b0 = n_busy_rise;
    m_sda_low = 1'b1; wclk(1);
    m_sda_low = 1'b0; wclk(20);
`ifdef I2CS_GLITCH_FILTER_EN
    chk("glitch/start_seen", n_busy_rise - b0, 0);
`else
    chk("glitch/start_seen", n_busy_rise - b0, 1);
`endif
    chk("glitch/busy_end", busy, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int nb;
      q = {};
      q.push_back(($urandom_range(0, 1) == 0) ? WADDR : 8'($urandom_range(0, 255)));
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) q.push_back(8'($urandom_range(0, 255)));
      txn($sformatf("rnd%0d", t), q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/i2cs_rx.md
I2CS_RX -- requirements
Module: i2cs_rx

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit target address it responds to.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port i2c_sclk, input, 1, bus clock driven by the initiator; asynchronous to clk.
REQ-005 SHALL have port i2c_sdat, inout, 1, open-drain data line; drives only 0 or high-Z.
REQ-006 SHALL have port dout, output, 16, last received word: {byte1, byte2}.
REQ-007 SHALL have port dout_valid, output, 1, one-clk pulse when dout is updated.
REQ-008 SHALL have port busy, output, 1, high from START until STOP or abort.
REQ-009 SHALL have port frame_err, output, 1, one-clk pulse on a malformed transfer.

Function
REQ-010 SHALL pass i2c_sclk and i2c_sdat through 2-flop synchronisers; all detection uses the synchronised values (scl_s, sda_s).
REQ-011 SHALL detect START as sda_s 1->0 while scl_s=1, and STOP as sda_s 0->1 while scl_s=1.
REQ-012 SHALL sample data bits on the scl_s rising edge, MSB first, and change SDA drive only on the scl_s falling edge.
REQ-013 SHALL implement states IDLE, ADDR, AACK, DATA, DACK, WAITP.
REQ-014 IDLE->ADDR on START; busy=1.
REQ-015 ADDR: shift 8 bits; after bit 8, if byte[7:1]==DEV_ADDR and byte[0]==0 -> AACK, else -> WAITP with SDA released (NACK).
REQ-016 AACK/DACK: drive SDA low from the falling edge after bit 8 until the falling edge after the 9th clock, then release.
REQ-017 AACK->DATA; DATA shifts 8 bits -> DACK; DACK->DATA for byte 1, and for byte 2 updates dout and pulses dout_valid on the releasing falling edge, then -> WAITP.
REQ-018 WAITP SHALL ignore all bits, never drive SDA, and NACK any third data byte.
REQ-019 STOP in any state SHALL go to IDLE with busy=0 and SDA released.
REQ-020 A STOP before the word completes SHALL pulse frame_err, discard the partial word, and keep dout unchanged.
REQ-021 A repeated START in any non-IDLE state SHALL go to ADDR and clear the bit counter and the partial word.
REQ-022 A START or STOP detected while driving ACK SHALL release SDA in the same clk cycle.
REQ-023 The bit counter SHALL count 0..8 and wrap to 0 on each 9th falling edge.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set state IDLE, SDA high-Z, dout=16'h0000, dout_valid=0, busy=0, frame_err=0, and clear the counter and synchronisers to 1.
REQ-025 Reset asserted mid-transaction SHALL abort with no dout_valid and no frame_err; the next START SHALL begin cleanly.

Configuration
REQ-026 Macro I2CS_GLITCH_FILTER_EN defined: scl_s and sda_s SHALL additionally pass a 3-sample majority filter (+2 clk latency), rejecting pulses of 1 clk width.
REQ-027 Macro undefined: no filter; synchroniser output feeds detection directly.

Verification
REQ-028 Write 0x34, 0x1E, 0x00, then STOP -> three ACKs (SDA=0 on the 9th clocks), dout=16'h1E00, one dout_valid pulse.
REQ-029 Address byte 0x36 -> SDA never driven, no dout_valid, busy falls at STOP.
REQ-030 Address byte 0x35 (read) -> NACK, WAITP, no dout_valid.
REQ-031 0x34, 0x0E, then STOP -> frame_err pulse, dout holds its previous value.
REQ-032 0x34, 0x02, repeated START, 0x34, 0x04, 0x79, STOP -> dout=16'h0479, exactly one dout_valid.
REQ-033 With I2CS_GLITCH_FILTER_EN, a 1-clk low glitch on SDA while SCL is high -> no START/STOP detected; without the macro -> a START is detected.
